// File: rtl/sad_stream_tx.sv
`timescale 1ns/1ps
// sad_stream_tx: captures a bank of N candidate SADs in one handshake and
// replays it as a serial (sad, index) stream for the SAD comparator tree.
//
// Ports:
//   Clk, Rst_n             clock (rising edge) and async active-low reset
//   load_valid/load_ready  bank handshake; sad_vec lane k at [k*SAD_W +: SAD_W]
//   sad_vec, base_index    bank of SADs and candidate index of lane 0
//   abort                  synchronous flush of the bank being streamed
//   out_valid/out_ready    per-beat stream handshake
//   sadOut, indexOut       current lane SAD and base_index + lane (wrapping)
//   out_last               current beat is lane N-1
//   busy                   a bank is held
module sad_stream_tx #(
  parameter int unsigned N     = 16,
  parameter int unsigned SAD_W = 32,
  parameter int unsigned IDX_W = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [N*SAD_W-1:0] sad_vec,
  input  logic [IDX_W-1:0]   base_index,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SAD_W-1:0]   sadOut,
  output logic [IDX_W-1:0]   indexOut,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [SAD_W-1:0]   bank_q [N];
  logic [IDX_W-1:0]   base_q;
  logic               load_en;
  logic               at_last;

  assign at_last = (ptr_q == LAST_PTR);

  // State, lane pointer and bank storage.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (load_en) begin
        base_q <= base_index;
        for (int unsigned k = 0; k < N; k++) begin
          bank_q[k] <= sad_vec[k*SAD_W +: SAD_W];
        end
      end
    end
  end

  // Next state and handshake outputs. load_ready is gated by Rst_n so that it
  // reads 0 while reset is asserted; the final-beat term gives zero-bubble
  // back-to-back banks.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    load_en    = 1'b0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = Rst_n;
        if (load_valid) begin
          load_en = 1'b1;
          ptr_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (abort) begin
          // Presented beat is dropped, not transferred; any load is ignored.
          state_d = IDLE;
          ptr_d   = '0;
        end else if (out_ready) begin
          if (at_last) begin
            load_ready = Rst_n;
            ptr_d      = '0;
            if (load_valid) begin
              load_en = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Beat payload comes straight from registered bank, base and pointer.
  assign sadOut   = bank_q[ptr_q];
  assign indexOut = base_q + IDX_W'(ptr_q);
  assign out_last = (state_q == SEND) && at_last;

endmodule

// File: tb/tb_sad_stream_tx.sv
`timescale 1ns/1ps
// tb_sad_stream_tx: randomized scoreboard bench for sad_stream_tx.
module tb_sad_stream_tx;

  localparam int unsigned N     = 16;
  localparam int unsigned SAD_W = 32;
  localparam int unsigned IDX_W = 32;

  logic               Clk;
  logic               Rst_n;
  logic               load_valid;
  logic               load_ready;
  logic [N*SAD_W-1:0] sad_vec;
  logic [IDX_W-1:0]   base_index;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [SAD_W-1:0]   sadOut;
  logic [IDX_W-1:0]   indexOut;
  logic               out_last;
  logic               busy;

  sad_stream_tx #(.N(N), .SAD_W(SAD_W), .IDX_W(IDX_W)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sad_vec    (sad_vec),
    .base_index (base_index),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sadOut     (sadOut),
    .indexOut   (indexOut),
    .out_last   (out_last),
    .busy       (busy)
  );

  typedef struct {
    logic [SAD_W-1:0] sad;
    logic [IDX_W-1:0] idx;
    logic             last;
  } beat_t;

  beat_t            exp_q[$];
  logic [SAD_W-1:0] cur_lanes [N];
  logic [IDX_W-1:0] cur_base;
  int errors     = 0;
  int checks     = 0;
  int xfer_cnt   = 0;
  int loads_acc  = 0;
  int ready_mode = 0;
  int rcnt       = 0;
  int x0;
  int cyc;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream readiness: 0 = always ready, 1 = 1,0,0 pattern, else random.
  always @(posedge Clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rcnt % 3 == 1);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: model sees the bank as a list of pending beats. A bank is held
  // while beats remain; a new bank is accepted when none remain, or when the
  // last one leaves this cycle without abort.
  always @(negedge Clk) begin : sb
    int pre;
    bit lr_exp;
    if (!Rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_load_ready", 64'(load_ready), 64'(0));
      exp_q.delete();
    end else begin
      pre    = exp_q.size();
      lr_exp = (pre == 0) || (pre == 1 && out_ready && !abort);
      chk("out_valid", 64'(out_valid), 64'(pre > 0));
      chk("busy", 64'(busy), 64'(pre > 0));
      chk("load_ready", 64'(load_ready), 64'(lr_exp));
      if (pre > 0) begin
        chk("sadOut", 64'(sadOut), 64'(exp_q[0].sad));
        chk("indexOut", 64'(indexOut), 64'(exp_q[0].idx));
        chk("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (abort) begin
          exp_q.delete();
        end else if (out_ready) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
      if (load_valid && lr_exp) begin
        for (int k = 0; k < int'(N); k++) begin
          beat_t b;
          b.sad  = cur_lanes[k];
          b.idx  = cur_base + IDX_W'(k);
          b.last = (k == int'(N) - 1);
          exp_q.push_back(b);
        end
        loads_acc++;
      end
    end
  end

  // kind 0: lanes off+k; 1: alternating 0 / all-ones; else random.
  task automatic set_bank(input int kind, input logic [IDX_W-1:0] base, input int off);
    for (int k = 0; k < int'(N); k++) begin
      case (kind)
        0:       cur_lanes[k] = SAD_W'(off + k);
        1:       cur_lanes[k] = (k % 2 == 1) ? {SAD_W{1'b1}} : {SAD_W{1'b0}};
        default: cur_lanes[k] = SAD_W'($urandom);
      endcase
      sad_vec[k*SAD_W +: SAD_W] = cur_lanes[k];
    end
    cur_base   = base;
    base_index = base;
  endtask

  task automatic load_bank(input int kind, input logic [IDX_W-1:0] base, input int off);
    int n0;
    n0 = loads_acc;
    set_bank(kind, base, off);
    load_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge Clk);
      if (loads_acc != n0) break;
    end
    chk("load_accept", 64'(loads_acc != n0), 64'(1));
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 400; i++) begin
      @(posedge Clk);
      if (xfer_cnt >= target) break;
    end
    chk("beat_reach", 64'(xfer_cnt >= target), 64'(1));
  endtask

  initial begin
    Rst_n      = 1'b0;
    load_valid = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    sad_vec    = '0;
    base_index = '0;
    cur_base   = '0;
    for (int k = 0; k < int'(N); k++) cur_lanes[k] = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_load_ready", 64'(load_ready), 64'(0));
    chk("reset_out_last", 64'(out_last), 64'(0));
    chk("reset_sadOut", 64'(sadOut), 64'(0));
    chk("reset_indexOut", 64'(indexOut), 64'(0));
    #2 Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // basic stream
    ready_mode = 0;
    load_bank(0, 32'h40, 100);
    wait_idle();

    // backpressure
    ready_mode = 1;
    load_bank(0, 32'h200, 300);
    wait_idle();

    // back-to-back banks: 32 beats in 32 cycles
    ready_mode = 0;
    load_bank(0, 32'h0, 100);
    x0  = xfer_cnt;
    cyc = 0;
    fork
      load_bank(0, 32'h100, 200);
      begin
        for (int i = 0; i < 64; i++) begin
          @(posedge Clk);
          cyc++;
          if (xfer_cnt >= x0 + 32) break;
        end
      end
    join
    chk("b2b_cycles", 64'(cyc), 64'(32));
    wait_idle();

    // index wrap
    ready_mode = 2;
    load_bank(0, 32'hFFFF_FFFE, 500);
    wait_idle();

    // abort at beat 5
    ready_mode = 0;
    load_bank(0, 32'h40, 100);
    x0 = xfer_cnt;
    wait_xfers(x0 + 5);
    #1 abort = 1'b1;
    @(posedge Clk);
    #1 abort = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_load_ready", 64'(load_ready), 64'(1));
    load_bank(0, 32'h80, 700);
    wait_idle();

    // abort in IDLE does not block a load
    abort = 1'b1;
    load_bank(0, 32'h10, 900);
    abort = 1'b0;
    wait_idle();

    // reset at beat 7, checked between clock edges
    load_bank(0, 32'h300, 100);
    x0 = xfer_cnt;
    wait_xfers(x0 + 7);
    #3 Rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_load_ready", 64'(load_ready), 64'(0));
    chk("midrst_out_last", 64'(out_last), 64'(0));
    chk("midrst_sadOut", 64'(sadOut), 64'(0));
    chk("midrst_indexOut", 64'(indexOut), 64'(0));
    repeat (2) @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    load_bank(0, 32'h40, 100);
    wait_idle();

    // extremes
    ready_mode = 2;
    load_bank(1, 32'h0, 0);
    wait_idle();

    // random banks, some back-to-back
    for (int r = 0; r < 6; r++) begin
      ready_mode = (r % 2 == 1) ? 2 : 0;
      load_bank(2, IDX_W'($urandom), 0);
      if (r % 2 == 1) load_bank(2, IDX_W'($urandom), 0);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
